// File: rtl/loader_ctrl_if.sv
// ---------------------------------------------------------------------------
// loader_ctrl_if : host byte link plus the IRAM/DRAM loader-side bus
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface loader_ctrl_if;
  logic       dc_i;
  logic       byte_rdy_i;
  logic [7:0] byte_data_i;
  logic       iram_wr_done_i;
  logic       dram_wr_done_i;
  logic       iram_dc_o;
  logic       iram_byte_rdy_o;
  logic       dram_dc_o;
  logic       dram_byte_rdy_o;
  logic [7:0] byte_data_o;
  logic       iram_sel_o;
  logic       dram_sel_o;
  logic       cpu_rst_n_o;
  logic       busy_o;
  logic       err_o;

  modport slave (
    input  dc_i, byte_rdy_i, byte_data_i, iram_wr_done_i, dram_wr_done_i,
    output iram_dc_o, iram_byte_rdy_o, dram_dc_o, dram_byte_rdy_o,
           byte_data_o, iram_sel_o, dram_sel_o, cpu_rst_n_o, busy_o, err_o
  );

  modport master (
    output dc_i, byte_rdy_i, byte_data_i, iram_wr_done_i, dram_wr_done_i,
    input  iram_dc_o, iram_byte_rdy_o, dram_dc_o, dram_byte_rdy_o,
           byte_data_o, iram_sel_o, dram_sel_o, cpu_rst_n_o, busy_o, err_o
  );
endinterface

`default_nettype wire

// File: rtl/loader_ctrl.sv
// ---------------------------------------------------------------------------
// loader_ctrl : decodes host commands, steers payload to the IRAM/DRAM loader
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module loader_ctrl #(
  parameter logic [7:0] IRAM_WR_ST = 8'h2a,
  parameter logic [7:0] IRAM_WR_SP = 8'h2b,
  parameter logic [7:0] DRAM_WR_ST = 8'h2c,
  parameter logic [7:0] DRAM_WR_SP = 8'h2d,
  parameter logic [7:0] CPU_RST    = 8'h2e,
  parameter logic [7:0] CPU_RUN    = 8'h2f,
  parameter logic [7:0] LDR_WR_ST  = 8'h2a,
  parameter logic [7:0] LDR_WR_SP  = 8'h2b
) (
  input  wire logic     clk_i,
  input  wire logic     rst_n_i,
  loader_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_IRAM_WR   = 3'd1;
  localparam logic [2:0] S_DRAM_WR   = 3'd2;
  localparam logic [2:0] S_IRAM_WAIT = 3'd3;
  localparam logic [2:0] S_DRAM_WAIT = 3'd4;

  logic [2:0] state_q, state_d;
  logic       iram_dc_q, iram_dc_d, iram_rdy_q, iram_rdy_d;
  logic       dram_dc_q, dram_dc_d, dram_rdy_q, dram_rdy_d;
  logic [7:0] data_q, data_d;
  logic       iram_sel_q, iram_sel_d, dram_sel_q, dram_sel_d;
  logic       cpu_rst_n_q, cpu_rst_n_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;

  logic       w_cmd, w_dat, w_is_iram;

  assign w_cmd     = bus.byte_rdy_i & ~bus.dc_i;
  assign w_dat     = bus.byte_rdy_i &  bus.dc_i;
  assign w_is_iram = (state_q == S_IRAM_WR);

  always_comb begin
    state_d     = state_q;
    iram_dc_d   = 1'b0;
    iram_rdy_d  = 1'b0;
    dram_dc_d   = 1'b0;
    dram_rdy_d  = 1'b0;
    data_d      = data_q;
    iram_sel_d  = iram_sel_q;
    dram_sel_d  = dram_sel_q;
    cpu_rst_n_d = cpu_rst_n_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (w_dat) begin
          err_d = 1'b1;
        end else if (w_cmd) begin
          case (bus.byte_data_i)
            CPU_RST: begin
              cpu_rst_n_d = 1'b0;
              err_d       = 1'b0;
            end
            CPU_RUN: cpu_rst_n_d = 1'b1;
            IRAM_WR_ST: begin
              // A load is only accepted while the CPU is parked in reset.
              if (cpu_rst_n_q) begin
                err_d = 1'b1;
              end else begin
                iram_sel_d = 1'b1;
                iram_rdy_d = 1'b1;
                data_d     = LDR_WR_ST;
                state_d    = S_IRAM_WR;
              end
            end
            DRAM_WR_ST: begin
              if (cpu_rst_n_q) begin
                err_d = 1'b1;
              end else begin
                dram_sel_d = 1'b1;
                dram_rdy_d = 1'b1;
                data_d     = LDR_WR_ST;
                state_d    = S_DRAM_WR;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      S_IRAM_WR, S_DRAM_WR: begin
        if (w_dat) begin
          iram_rdy_d = w_is_iram;
          iram_dc_d  = w_is_iram;
          dram_rdy_d = ~w_is_iram;
          dram_dc_d  = ~w_is_iram;
          data_d     = bus.byte_data_i;
        end else if (w_cmd) begin
          if (bus.byte_data_i == (w_is_iram ? IRAM_WR_SP : DRAM_WR_SP)) begin
            iram_rdy_d = w_is_iram;
            dram_rdy_d = ~w_is_iram;
            data_d     = LDR_WR_SP;
            state_d    = w_is_iram ? S_IRAM_WAIT : S_DRAM_WAIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_IRAM_WAIT: begin
        if (bus.byte_rdy_i) err_d = 1'b1;
        if (bus.iram_wr_done_i) begin
          iram_sel_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      S_DRAM_WAIT: begin
        if (bus.byte_rdy_i) err_d = 1'b1;
        if (bus.dram_wr_done_i) begin
          dram_sel_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      iram_dc_q   <= 1'b0;
      iram_rdy_q  <= 1'b0;
      dram_dc_q   <= 1'b0;
      dram_rdy_q  <= 1'b0;
      data_q      <= 8'h00;
      iram_sel_q  <= 1'b0;
      dram_sel_q  <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      iram_dc_q   <= iram_dc_d;
      iram_rdy_q  <= iram_rdy_d;
      dram_dc_q   <= dram_dc_d;
      dram_rdy_q  <= dram_rdy_d;
      data_q      <= data_d;
      iram_sel_q  <= iram_sel_d;
      dram_sel_q  <= dram_sel_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign bus.iram_dc_o       = iram_dc_q;
  assign bus.iram_byte_rdy_o = iram_rdy_q;
  assign bus.dram_dc_o       = dram_dc_q;
  assign bus.dram_byte_rdy_o = dram_rdy_q;
  assign bus.byte_data_o     = data_q;
  assign bus.iram_sel_o      = iram_sel_q;
  assign bus.dram_sel_o      = dram_sel_q;
  assign bus.cpu_rst_n_o     = cpu_rst_n_q;
  assign bus.busy_o          = busy_q;
  assign bus.err_o           = err_q;

endmodule

`default_nettype wire

// File: tb/tb_loader_ctrl.sv
// ---------------------------------------------------------------------------
// tb_loader_ctrl : directed + random stimulus against a transaction-level model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_loader_ctrl;

  logic clk_i = 1'b0;
  logic rst_n_i;
  always #5 clk_i = ~clk_i;

  loader_ctrl_if bus ();

  loader_ctrl u_dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: which RAM is being loaded (0 none, 1 IRAM, 2 DRAM), whether the
  // stop code has gone out, CPU hold, error flag and the last loader byte.
  int         m_tgt;
  bit         m_stopped;
  bit         m_held;
  bit         m_err;
  logic [7:0] m_data;
  bit         m_irdy, m_drdy, m_idc, m_ddc;

  task automatic model_reset();
    m_tgt = 0; m_stopped = 0; m_held = 1; m_err = 0; m_data = 8'h00;
    m_irdy = 0; m_drdy = 0; m_idc = 0; m_ddc = 0;
  endtask

  task automatic emit(input int t, input bit dc, input logic [7:0] b);
    if (t == 1) begin m_irdy = 1; m_idc = dc; end
    else        begin m_drdy = 1; m_ddc = dc; end
    m_data = b;
  endtask

  task automatic model(input bit dc, input bit rdy, input logic [7:0] b,
                       input bit idn, input bit ddn);
    int t  = m_tgt;
    bit st = m_stopped;
    m_irdy = 0; m_drdy = 0; m_idc = 0; m_ddc = 0;
    if (rdy) begin
      if (t == 0) begin
        if (dc)                  m_err = 1;
        else if (b == 8'h2e)     begin m_held = 1; m_err = 0; end
        else if (b == 8'h2f)     m_held = 0;
        else if (b == 8'h2a || b == 8'h2c) begin
          if (!m_held) m_err = 1;
          else begin
            m_tgt = (b == 8'h2a) ? 1 : 2;
            m_stopped = 0;
            emit(m_tgt, 0, 8'h2a);
          end
        end else m_err = 1;
      end else if (!st) begin
        if (dc) emit(t, 1, b);
        else if (b == ((t == 1) ? 8'h2b : 8'h2d)) begin
          emit(t, 0, 8'h2b);
          m_stopped = 1;
        end else m_err = 1;
      end else m_err = 1;
    end
    if (t != 0 && st && ((t == 1 && idn) || (t == 2 && ddn))) begin
      m_tgt = 0; m_stopped = 0;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("iram_byte_rdy", {7'd0, bus.iram_byte_rdy_o}, {7'd0, m_irdy});
    check("iram_dc",       {7'd0, bus.iram_dc_o},       {7'd0, m_idc});
    check("dram_byte_rdy", {7'd0, bus.dram_byte_rdy_o}, {7'd0, m_drdy});
    check("dram_dc",       {7'd0, bus.dram_dc_o},       {7'd0, m_ddc});
    check("byte_data",     bus.byte_data_o,             m_data);
    check("iram_sel",      {7'd0, bus.iram_sel_o},      {7'd0, m_tgt == 1});
    check("dram_sel",      {7'd0, bus.dram_sel_o},      {7'd0, m_tgt == 2});
    check("cpu_rst_n",     {7'd0, bus.cpu_rst_n_o},     {7'd0, !m_held});
    check("busy",          {7'd0, bus.busy_o},          {7'd0, m_tgt != 0});
    check("err",           {7'd0, bus.err_o},           {7'd0, m_err});
  endtask

  task automatic step(input bit dc, input bit rdy, input logic [7:0] b,
                      input bit idn, input bit ddn);
    @(negedge clk_i);
    bus.dc_i = dc; bus.byte_rdy_i = rdy; bus.byte_data_i = b;
    bus.iram_wr_done_i = idn; bus.dram_wr_done_i = ddn;
    @(posedge clk_i);
    model(dc, rdy, b, idn, ddn);
    #1;
    check_all();
  endtask

  task automatic cmd(input logic [7:0] b); step(0, 1, b, 0, 0); endtask
  task automatic dat(input logic [7:0] b); step(1, 1, b, 0, 0); endtask
  task automatic idle();                   step(0, 0, 8'($urandom), 0, 0); endtask

  initial begin
    rst_n_i = 1'b0;
    bus.dc_i = 0; bus.byte_rdy_i = 0; bus.byte_data_i = 8'h00;
    bus.iram_wr_done_i = 0; bus.dram_wr_done_i = 0;
    model_reset();
    #3;
    check_all();
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // IRAM load of 0x00..0x3f, done 3 cycles after stop
    cmd(8'h2e);
    cmd(8'h2a);
    for (int i = 0; i < 64; i++) dat(8'(i));
    cmd(8'h2b);
    idle(); idle();
    step(0, 0, 8'h00, 1, 0);
    idle();

    // DRAM load, back-to-back strobes
    cmd(8'h2c); dat(8'ha5); dat(8'h5a); cmd(8'h2d);
    idle();
    step(0, 0, 8'h00, 0, 1);
    idle();

    // Start refused while CPU runs; CPU_RST clears error
    cmd(8'h2f); cmd(8'h2a); idle(); cmd(8'h2e);

    // Bad commands mid-load, then crossed done pulses in IRAM_WAIT
    cmd(8'h2a); cmd(8'h2d); dat(8'h11); cmd(8'h2f); cmd(8'h2b);
    step(0, 0, 8'h00, 0, 1);
    idle();
    step(0, 0, 8'h00, 1, 0);
    cmd(8'h2e);

    // Asynchronous reset in the middle of a DRAM load
    cmd(8'h2c);
    for (int i = 0; i < 10; i++) dat(8'($urandom));
    @(negedge clk_i);
    bus.byte_rdy_i = 0;
    #2;
    rst_n_i = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk_i);
    #1;
    check_all();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    cmd(8'h2a);
    for (int i = 0; i < 8; i++) dat(8'($urandom));
    cmd(8'h2b); idle();
    step(0, 0, 8'h00, 1, 0);

    // Randomized traffic biased toward the command codes
    for (int n = 0; n < 1500; n++) begin
      bit         r_dc  = ($urandom_range(0, 2) == 0);
      bit         r_rdy = ($urandom_range(0, 3) != 0);
      logic [7:0] r_b   = (!r_dc && $urandom_range(0, 9) != 0) ?
                          8'(8'h2a + $urandom_range(0, 5)) : 8'($urandom);
      step(r_dc, r_rdy, r_b, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
